// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S datapath: decoded instruction set, opcodes,
// ALU operation encoding and the flag bundle.
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNEG,
    I_BOV,
    I_BNOV,
    I_BNNEG,
    I_BNZERO,
    I_CALL,
    I_RET,
    I_HALT
  } decoded_instruction_type;

  // Opcodes live in IR[15:8]
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_CALL   = 8'h07;
  localparam logic [7:0] OP_RET    = 8'h08;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic uov;  // carry on add, borrow on sub
    logic sov;
  } flags_t;

endpackage

// File: rtl/k_and_s_ret_stack.sv
// Return-address stack for CALL/RET. push/pop arrive already qualified by
// the PC update strobe. Misuse (push+pop together, pop when empty, push
// when full) leaves the stack untouched and sets a sticky error.
module k_and_s_ret_stack #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [IW-1:0]    top_idx;

  assign empty   = (ptr == '0);
  assign full    = (ptr == PW'(DEPTH));
  assign top_idx = ptr[IW-1:0] - IW'(1);
  // Only meaningful when non-empty; the PC logic ignores it otherwise.
  assign top     = mem[top_idx];

  // Occupancy pointer and sticky error flag
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      err <= 1'b0;
    end else if (push && pop) begin
      err <= 1'b1;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       ptr <= ptr - PW'(1);
    end else if (push) begin
      if (full) err <= 1'b1;
      else      ptr <= ptr + PW'(1);
    end
  end

  // Entry storage, written on a legal push
  // NOTE: storage has no reset; emptiness is tracked by ptr alone, so the
  // contents never need clearing and map onto plain flops/RAM without reset.
  always_ff @(posedge clk) begin
    if (push && !pop && !full) mem[ptr[IW-1:0]] <= din;
  end

endmodule

// File: rtl/k_and_s_data_path_gen2.sv
// K&S datapath, generation 2: IR, 5-bit PC, 4 x DATA_W register file,
// ALU with registered flags, and a CALL/RET return-address stack.
module k_and_s_data_path_gen2
  import k_and_s_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic                    stack_push,
  input  logic                    stack_pop,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [4:0]              ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    stack_empty,
  output logic                    stack_full,
  output logic                    stack_err
);

  if (DATA_W < 16) begin : g_bad_data_w
    $error("k_and_s_data_path_gen2: DATA_W must be >= 16");
  end
  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("k_and_s_data_path_gen2: STACK_DEPTH must be >= 1");
  end

  logic [15:0]       ir;
  logic [4:0]        pc;
  logic [DATA_W-1:0] regs [4];
  logic [1:0]        a_addr, b_addr, c_addr;
  logic [4:0]        mem_addr;
  logic [DATA_W-1:0] bus_a, bus_b, bus_c;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_eff;
  flags_t            alu_flags, flags_q;
  logic              push_q, pop_q;
  logic [4:0]        stack_top;
  logic              unused_ir_bit;

  // IR[7] carries no field in any instruction format
  assign unused_ir_bit = ir[7];

  // Instruction decode: opcode plus register/address fields, zero when unused
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    decoded_instruction = I_NOP;
    a_addr   = 2'd0;
    b_addr   = 2'd0;
    c_addr   = 2'd0;
    mem_addr = 5'd0;
    case (ir[15:8])
      OP_LOAD:   begin decoded_instruction = I_LOAD;  c_addr = ir[6:5]; mem_addr = ir[4:0]; end
      OP_STORE:  begin decoded_instruction = I_STORE; a_addr = ir[6:5]; mem_addr = ir[4:0]; end
      OP_MOVE:   begin decoded_instruction = I_MOVE;  c_addr = ir[3:2]; a_addr = ir[1:0]; b_addr = ir[1:0]; end
      OP_ADD:    begin decoded_instruction = I_ADD;   a_addr = ir[1:0]; b_addr = ir[3:2]; c_addr = ir[5:4]; end
      OP_SUB:    begin decoded_instruction = I_SUB;   a_addr = ir[1:0]; b_addr = ir[3:2]; c_addr = ir[5:4]; end
      OP_AND:    begin decoded_instruction = I_AND;   a_addr = ir[1:0]; b_addr = ir[3:2]; c_addr = ir[5:4]; end
      OP_OR:     begin decoded_instruction = I_OR;    a_addr = ir[1:0]; b_addr = ir[3:2]; c_addr = ir[5:4]; end
      OP_BRANCH: begin decoded_instruction = I_BRANCH; mem_addr = ir[4:0]; end
      OP_BZERO:  begin decoded_instruction = I_BZERO;  mem_addr = ir[4:0]; end
      OP_BNEG:   begin decoded_instruction = I_BNEG;   mem_addr = ir[4:0]; end
      OP_BOV:    begin decoded_instruction = I_BOV;    mem_addr = ir[4:0]; end
      OP_BNOV:   begin decoded_instruction = I_BNOV;   mem_addr = ir[4:0]; end
      OP_BNNEG:  begin decoded_instruction = I_BNNEG;  mem_addr = ir[4:0]; end
      OP_BNZERO: begin decoded_instruction = I_BNZERO; mem_addr = ir[4:0]; end
      OP_CALL:   begin decoded_instruction = I_CALL;   mem_addr = ir[4:0]; end
      OP_RET:    decoded_instruction = I_RET;
      OP_HALT:   decoded_instruction = I_HALT;
      default:   decoded_instruction = I_NOP;
    endcase
  end

  // Register file reads are combinational
  assign bus_a    = regs[a_addr];
  assign bus_b    = regs[b_addr];
  assign bus_c    = c_sel ? alu_result : data_in;
  assign data_out = bus_a;
  assign ram_addr = addr_sel ? mem_addr : pc;

  // ALU: result and the flags it would produce this cycle
  always_comb begin
    sum        = '0;
    b_eff      = bus_b;
    alu_result = '0;
    alu_flags  = '0;
    case (alu_op_t'(operation))
      ALU_ADD: begin
        sum            = {1'b0, bus_a} + {1'b0, bus_b};
        alu_result     = sum[DATA_W-1:0];
        alu_flags.uov  = sum[DATA_W];
      end
      ALU_SUB: begin
        b_eff          = ~bus_b;
        sum            = {1'b0, bus_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, 1'b1};
        alu_result     = sum[DATA_W-1:0];
        alu_flags.uov  = ~sum[DATA_W];
      end
      ALU_AND: alu_result = bus_a & bus_b;
      ALU_OR:  alu_result = bus_a | bus_b;
      default: alu_result = '0;
    endcase
    if (operation == ALU_ADD || operation == ALU_SUB) begin
      alu_flags.sov = (bus_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (alu_result[DATA_W-1] != bus_a[DATA_W-1]);
    end
    alu_flags.zero = (alu_result == '0);
    alu_flags.neg  = alu_result[DATA_W-1];
  end

  // Instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ir <= 16'h0000;
    else if (ir_enable) ir <= data_in[15:0];
  end

  // Register file write port, reset to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (write_reg_enable) begin
      regs[c_addr] <= bus_c;
    end
  end

  // Flags register, holds unless explicitly loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                flags_q <= '0;
    else if (flags_reg_enable) flags_q <= alu_flags;
  end

  assign zero_op           = flags_q.zero;
  assign neg_op            = flags_q.neg;
  assign unsigned_overflow = flags_q.uov;
  assign signed_overflow   = flags_q.sov;

  // Stack requests only count together with a PC update
  assign push_q = pc_enable & stack_push;
  assign pop_q  = pc_enable & stack_pop;

  k_and_s_ret_stack #(
    .WIDTH (5),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop_q),
    .din   (pc),
    .top   (stack_top),
    .empty (stack_empty),
    .full  (stack_full),
    .err   (stack_err)
  );

  // Program counter: RET/CALL take precedence over plain branch; misuse falls back to PC+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= 5'd0;
    end else if (pc_enable) begin
      if (stack_push && stack_pop)  pc <= pc + 5'd1;
      else if (stack_pop)           pc <= stack_empty ? pc + 5'd1 : stack_top;
      else if (stack_push)          pc <= mem_addr;
      else if (branch)              pc <= mem_addr;
      else                          pc <= pc + 5'd1;
    end
  end

endmodule

// File: tb/tb_k_and_s_data_path_gen2.sv
// Self-checking bench: a 16-bit/depth-4 and a 32-bit/depth-2 datapath share
// the control inputs; each is checked where its parameters matter.
module tb_k_and_s_data_path_gen2;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic write_reg_enable, flags_reg_enable, stack_push, stack_pop;
  logic [1:0]  operation;
  logic [15:0] din16;
  logic [31:0] din32;

  decoded_instruction_type dec16, dec32;
  logic z16, n16, u16, s16, z32, n32, u32, s32;
  logic [4:0]  ram16, ram32;
  logic [15:0] dout16;
  logic [31:0] dout32;
  logic emp16, full16, err16, emp32, full32, err32;

  k_and_s_data_path_gen2 #(.DATA_W(16), .STACK_DEPTH(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .stack_push(stack_push),
    .stack_pop(stack_pop), .decoded_instruction(dec16), .zero_op(z16),
    .neg_op(n16), .unsigned_overflow(u16), .signed_overflow(s16),
    .ram_addr(ram16), .data_out(dout16), .data_in(din16),
    .stack_empty(emp16), .stack_full(full16), .stack_err(err16));

  k_and_s_data_path_gen2 #(.DATA_W(32), .STACK_DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .stack_push(stack_push),
    .stack_pop(stack_pop), .decoded_instruction(dec32), .zero_op(z32),
    .neg_op(n32), .unsigned_overflow(u32), .signed_overflow(s32),
    .ram_addr(ram32), .data_out(dout32), .data_in(din32),
    .stack_empty(emp32), .stack_full(full32), .stack_err(err32));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, s;
    logic        z, n, uov, sov;
  } alu_vec_t;

  typedef struct {
    logic [15:0]             ir;
    decoded_instruction_type d;
    logic [4:0]              mem;
  } dec_vec_t;

  alu_vec_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    write_reg_enable = 0; flags_reg_enable = 0; stack_push = 0; stack_pop = 0;
    operation = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_ir(input logic [15:0] instr);
    ir_enable = 1; din16 = instr; din32 = {16'h0, instr};
    tick(); idle();
  endtask

  task automatic load_reg(input logic [1:0] r, input logic [15:0] v16, input logic [31:0] v32);
    load_ir({8'h81, 1'b0, r, 5'd0});
    c_sel = 0; write_reg_enable = 1; din16 = v16; din32 = v32;
    tick(); idle();
  endtask

  task automatic alu_exec(input logic [1:0] op, input logic upd_flags);
    logic [7:0] opc;
    opc = 8'hA1 + {6'd0, op};
    load_ir({opc, 2'b00, 2'd3, 2'd2, 2'd1});  // c=R3, b=R2, a=R1
    operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = upd_flags;
    tick(); idle();
  endtask

  task automatic store_reg(input logic [1:0] r);
    load_ir({8'h82, 1'b0, r, 5'd0});
  endtask

  alu_vec_t alu_vecs[8];
  dec_vec_t dec_vecs[17];
  logic [4:0] exp_ram16[4], exp_ram32[4];
  logic       exp_err16[4], exp_emp16[4], exp_emp32[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    alu_vecs = '{
      '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1},
      '{2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0},
      '{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0},
      '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
      '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1},
      '{2'b10, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0},
      '{2'b11, 16'h8000, 16'h0001, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0},
      '{2'b10, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}
    };
    dec_vecs = '{
      '{16'h0000, I_NOP,    5'h00}, '{16'h815F, I_LOAD,   5'h1F},
      '{16'h8240, I_STORE,  5'h00}, '{16'h9106, I_MOVE,   5'h00},
      '{16'hA400, I_OR,     5'h00}, '{16'h0105, I_BRANCH, 5'h05},
      '{16'h0203, I_BZERO,  5'h03}, '{16'h0301, I_BNEG,   5'h01},
      '{16'h0502, I_BOV,    5'h02}, '{16'h0604, I_BNOV,   5'h04},
      '{16'h0A01, I_BNNEG,  5'h01}, '{16'h0B01, I_BNZERO, 5'h01},
      '{16'h0710, I_CALL,   5'h10}, '{16'h0800, I_RET,    5'h00},
      '{16'hFF00, I_HALT,   5'h00}, '{16'h421F, I_NOP,    5'h00},
      '{16'hA31C, I_AND,    5'h00}
    };
    exp_ram32 = '{5'h10, 5'h00, 5'h01, 5'h02};
    exp_emp32 = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_ram16 = '{5'h10, 5'h10, 5'h00, 5'h01};
    exp_emp16 = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_err16 = '{1'b0, 1'b0, 1'b0, 1'b1};
    din16 = '0; din32 = '0;

    // Reset state
    do_reset();
    check("rst_decode", dec16, I_NOP);
    check("rst_pc", ram16, 5'd0);
    check("rst_flags", {z16, n16, u16, s16}, 4'b0000);
    check("rst_flags32", {z32, n32, u32, s32}, 4'b0000);
    check("rst_stack", {emp16, full16, err16}, 3'b100);
    check("rst_stack32", {emp32, full32, err32}, 3'b100);
    check("rst_data_out", dout16, 16'h0000);

    // Decoder table
    foreach (dec_vecs[i]) begin
      load_ir(dec_vecs[i].ir);
      addr_sel = 1; #1;
      check($sformatf("dec_%04h", dec_vecs[i].ir), dec16, dec_vecs[i].d);
      check($sformatf("memaddr_%04h", dec_vecs[i].ir), ram16, dec_vecs[i].mem);
      addr_sel = 0;
    end

    // ALU table with scoreboard
    foreach (alu_vecs[i]) begin
      alu_vec_t e;
      load_reg(2'd1, alu_vecs[i].a, {16'h0, alu_vecs[i].a});
      load_reg(2'd2, alu_vecs[i].b, {16'h0, alu_vecs[i].b});
      sb_q.push_back(alu_vecs[i]);
      alu_exec(alu_vecs[i].op, 1'b1);
      e = sb_q.pop_front();
      check($sformatf("alu%0d_flags", i), {z16, n16, u16, s16}, {e.z, e.n, e.uov, e.sov});
      store_reg(2'd3);
      check($sformatf("alu%0d_result", i), dout16, e.s);
    end

    // Flags hold when not loaded (last vector left zero=1)
    alu_exec(2'b00, 1'b0);  // 00FF + FF00 = FFFF, flags disabled
    check("flags_hold", {z16, n16, u16, s16}, 4'b1000);
    store_reg(2'd3);
    check("noflag_result", dout16, 16'hFFFF);

    // CALL at PC=6, then RET
    do_reset();
    pc_enable = 1; repeat (6) tick(); idle();
    check("pc_six", ram16, 5'd6);
    din16 = 16'h0710; din32 = 32'h0710; ir_enable = 1; pc_enable = 1; tick(); idle();
    check("fetch_pc", ram16, 5'd7);
    check("fetch_dec", dec16, I_CALL);
    pc_enable = 1; stack_push = 1; tick(); idle();
    check("call_pc", ram16, 5'h10);
    check("call_pc32", ram32, 5'h10);
    check("call_nonempty", {emp16, err16}, 2'b00);
    load_ir(16'h0800);
    pc_enable = 1; stack_pop = 1; tick(); idle();
    check("ret_pc", ram16, 5'd7);
    check("ret_pc32", ram32, 5'd7);
    check("ret_empty", {emp16, err16, emp32, err32}, 4'b1010);

    // Asynchronous reset in the middle of a CALL
    load_ir(16'h0710);
    pc_enable = 1; stack_push = 1; tick();
    check("midcall_pushed", {ram16, emp16}, {5'h10, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", ram16, 5'd0);
    check("async_rst_stack", {emp16, emp32}, 2'b11);
    check("async_rst_ir", dec16, I_NOP);
    idle(); tick(); rst_n = 1'b1;

    // Stack requests without pc_enable are ignored
    stack_push = 1; tick(); idle();
    stack_pop = 1; tick(); idle();
    check("no_strobe", {ram16, emp16, err16}, {5'd0, 1'b1, 1'b0});

    // Push and pop together
    pc_enable = 1; stack_push = 1; stack_pop = 1; tick(); idle();
    check("pushpop_pc", ram16, 5'd1);
    check("pushpop_stack", {emp16, err16}, 2'b11);

    // Depth-2 overflow and underflow
    do_reset();
    load_ir(16'h0710);
    for (int i = 0; i < 3; i++) begin
      pc_enable = 1; stack_push = 1; tick(); idle();
      check($sformatf("call%0d_pc32", i), ram32, 5'h10);
      check($sformatf("call%0d_st32", i), {full32, err32}, {i >= 1, i == 2});
      check($sformatf("call%0d_st16", i), {full16, err16}, 2'b00);
    end
    load_ir(16'h0800);
    for (int i = 0; i < 4; i++) begin
      pc_enable = 1; stack_pop = 1; tick(); idle();
      check($sformatf("ret%0d_pc32", i), ram32, exp_ram32[i]);
      check($sformatf("ret%0d_st32", i), {emp32, err32}, {exp_emp32[i], 1'b1});
      check($sformatf("ret%0d_pc16", i), ram16, exp_ram16[i]);
      check($sformatf("ret%0d_st16", i), {emp16, err16}, {exp_emp16[i], exp_err16[i]});
    end

    // 32-bit LOAD/STORE and MOVE
    do_reset();
    load_reg(2'd2, 16'hBEEF, 32'hDEADBEEF);
    store_reg(2'd2);
    check("store32", dout32, 32'hDEADBEEF);
    check("store16", dout16, 16'hBEEF);
    load_ir(16'h9106);  // MOVE R1 <- R2
    operation = 2'b11; c_sel = 1; write_reg_enable = 1; tick(); idle();
    store_reg(2'd1);
    check("move32", dout32, 32'hDEADBEEF);

    // PC wrap 31 -> 0
    do_reset();
    pc_enable = 1; repeat (31) tick(); idle();
    check("pc_31", {ram16, ram32}, {5'd31, 5'd31});
    pc_enable = 1; tick(); idle();
    check("pc_wrap", {ram16, ram32}, {5'd0, 5'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
